// File: rtl/autoinstparam_pack.sv
// autoinstparam_pack: packs RATIO beats of BITSA bits into one output word.
//
// Beats are written to successive lanes of a fill register, with lane 0 in
// the least-significant bits. A word is handed to a one-deep output register
// when the last lane fills or when a beat arrives with in_last set. Lanes
// above the flushing beat are zero.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous, active-high reset
//   in_valid   - input beat present
//   in_ready   - beat accepted this cycle (= !out_valid || out_ready)
//   in_data    - beat payload, BITSA bits
//   in_last    - beat closes the current word early
//   out_valid  - packed word present
//   out_ready  - downstream accepts the word
//   out_data   - packed word, BITSA*RATIO bits
//   out_count  - number of valid lanes in out_data, 1..RATIO
//   out_parity - XOR of all valid-lane bits (only with the macro below)
//
// Build option: define AUTOINSTPARAM_PACK_PARITY_EN to add out_parity.

module autoinstparam_pack #(
   parameter int unsigned BITSA = 8,
   parameter int unsigned RATIO = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [BITSA-1:0]             in_data,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [BITSA*RATIO-1:0]       out_data,
   output logic [$clog2(RATIO+1)-1:0]   out_count
`ifdef AUTOINSTPARAM_PACK_PARITY_EN
   ,
   output logic                         out_parity
`endif
);

   localparam int unsigned W    = BITSA * RATIO;
   localparam int unsigned CW   = $clog2(RATIO + 1);
   localparam int unsigned CNTW = (RATIO > 1) ? $clog2(RATIO) : 1;

   logic [CNTW-1:0] r_cnt;
   logic [W-1:0]    r_fill;
   logic [W-1:0]    r_out_data;
   logic [CW-1:0]   r_out_count;
   logic            r_out_valid;

   logic            w_in_ready;
   logic            w_accept;
   logic            w_last_lane;
   logic            w_complete;
   logic [W-1:0]    w_word;

   assign w_in_ready  = !r_out_valid || out_ready;
   assign w_accept    = in_valid && w_in_ready;
   assign w_last_lane = (r_cnt == CNTW'(RATIO - 1));
   assign w_complete  = w_accept && (w_last_lane || in_last);

   // Lanes at and above r_cnt are always zero in the fill register, so
   // merging the incoming beat into lane r_cnt yields the complete word with
   // unused upper lanes already cleared.
   always_comb begin
      w_word = r_fill;
      for (int unsigned i = 0; i < RATIO; i++) begin
         if (CNTW'(i) == r_cnt) begin
            w_word[i*BITSA +: BITSA] = in_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_fill      <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_count <= '0;
      end else begin
         if (w_accept) begin
            if (w_complete) begin
               r_out_data  <= w_word;
               r_out_count <= CW'(r_cnt) + CW'(1);
               r_cnt       <= '0;
               r_fill      <= '0;
            end else begin
               r_fill <= w_word;
               r_cnt  <= r_cnt + CNTW'(1);
            end
         end
         // A completing beat can only be accepted when the output register is
         // empty or draining, so loading takes priority over clearing.
         if (w_complete) begin
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

`ifdef AUTOINSTPARAM_PACK_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_parity <= 1'b0;
      end else if (w_complete) begin
         r_parity <= ^w_word;
      end
   end

   assign out_parity = r_parity;
`endif

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_count = r_out_count;

endmodule
